// File: rtl/uart_rx_fifo_if.sv
// SFR-side bundle of the UART receive FIFO: pop/clear controls from the core,
// head byte, fill level, sticky error flags and receiver activity back to it.
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    logic                          rd_en;
    logic                          clr_err;
    logic [7:0]                    rx_data;
    logic                          rx_valid;
    logic [$clog2(FIFO_DEPTH):0]   rx_count;
    logic                          overrun;
    logic                          frame_err;
    logic                          busy;

    // The core / SFR read mux drives the pop and clear requests.
    modport master (
        output rd_en, clr_err,
        input  rx_data, rx_valid, rx_count, overrun, frame_err, busy
    );

    // The receiver answers with the buffered data and status.
    modport slave (
        input  rd_en, clr_err,
        output rx_data, rx_valid, rx_count, overrun, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO. The head byte
// is always visible on rx_data (0x00 when empty) and is popped by rd_en.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uart_rx,
    uart_rx_fifo_if.slave sfr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Line synchroniser and start-edge detection
    // ------------------------------------------------------------------
    logic       rx_meta_reg;
    logic       rx_s_reg;
    logic       rx_prev_reg;
    logic [1:0] sync_fill_reg;
    logic       armed_reg;
    logic       start_edge;

    // Two-flop synchroniser plus one delayed copy for edge detection; the
    // fill shift register tracks when rx_s really reflects the pin after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg   <= 1'b1;
            rx_s_reg      <= 1'b1;
            rx_prev_reg   <= 1'b1;
            sync_fill_reg <= 2'b00;
        end else begin
            rx_meta_reg   <= uart_rx;
            rx_s_reg      <= rx_meta_reg;
            rx_prev_reg   <= rx_s_reg;
            sync_fill_reg <= {sync_fill_reg[0], 1'b1};
        end
    end

    // A line that is low when reset is released must be seen high once before
    // a falling edge counts as a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_reg <= 1'b0;
        end else if (sync_fill_reg[1] && rx_s_reg) begin
            armed_reg <= 1'b1;
        end
    end

    assign start_edge = armed_reg && !rx_s_reg && rx_prev_reg;

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t          state_reg,   state_next;
    logic [TW-1:0]   tick_reg,    tick_next;
    logic [2:0]      bit_idx_reg, bit_idx_next;
    logic [7:0]      shift_reg,   shift_next;
    logic            push_req;
    logic            set_ovr;
    logic            set_ferr;

    logic [7:0]      mem_reg [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            ovr_reg;
    logic            ferr_reg;
    logic            fifo_valid;
    logic            pop;
    logic            has_space;

    assign fifo_valid = (count_reg != '0);
    assign pop        = sfr.rd_en && fifo_valid;
    // A same-cycle pop frees a slot for the byte completing in this cycle.
    assign has_space  = (count_reg < DEPTH_C) || pop;

    // FSM state, bit timer, bit index and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            tick_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            tick_reg    <= tick_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
        end
    end

    // Next-state logic: mid-bit sampling, byte assembly and stop-bit verdict.
    always_comb begin
        state_next   = state_reg;
        tick_next    = tick_reg + TW'(1);
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        push_req     = 1'b0;
        set_ovr      = 1'b0;
        set_ferr     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                tick_next = '0;
                if (start_edge) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (tick_reg == TICK_HALF) begin
                    tick_next    = '0;
                    bit_idx_next = '0;
                    // A start bit that has gone high again was only a glitch.
                    state_next   = rx_s_reg ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick_reg == TICK_LAST) begin
                    tick_next  = '0;
                    shift_next = {rx_s_reg, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick_reg == TICK_LAST) begin
                    tick_next = '0;
                    if (rx_s_reg) begin
                        state_next = ST_IDLE;
                        if (has_space) begin
                            push_req = 1'b1;
                        end else begin
                            set_ovr = 1'b1;
                        end
                    end else begin
                        set_ferr   = 1'b1;
                        state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Wait out the whole break so it reports a single error.
                tick_next = '0;
                if (rx_s_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                tick_next  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------

    // Storage write; the array itself needs no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push_req) begin
            mem_reg[wr_ptr_reg] <= shift_reg;
        end
    end

    // Pointers and fill level; simultaneous push and pop leave the level alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_req) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push_req && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push_req) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_reg  <= 1'b0;
            ferr_reg <= 1'b0;
        end else begin
            if (set_ovr) begin
                ovr_reg <= 1'b1;
            end else if (sfr.clr_err) begin
                ovr_reg <= 1'b0;
            end
            if (set_ferr) begin
                ferr_reg <= 1'b1;
            end else if (sfr.clr_err) begin
                ferr_reg <= 1'b0;
            end
        end
    end

    assign sfr.rx_data   = fifo_valid ? mem_reg[rd_ptr_reg] : 8'h00;
    assign sfr.rx_valid  = fifo_valid;
    assign sfr.rx_count  = count_reg;
    assign sfr.overrun   = ovr_reg;
    assign sfr.frame_err = ferr_reg;
    assign sfr.busy      = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: drives 8N1 frames bit by bit and compares the SFR
// side against a queue-based model of what a receiver should have buffered.
module tb_uart_rx_fifo;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    // Cycle (counted from the edge where the start bit is driven) in which the
    // stop bit is sampled: 3 cycles of sync/edge detect, half a bit of START,
    // eight data bits, then CPB-1 cycles into the stop bit.
    localparam int STOP_SAMPLE = 3 + CPB / 2 + 8 * CPB + CPB - 1;

    logic clk = 1'b0;
    logic rst;
    logic uart_rx;

    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) sfr_if ();

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .uart_rx(uart_rx),
        .sfr    (sfr_if)
    );

    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [7:0] model_q [$];
    logic       model_ovr;
    logic       model_ferr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_clear();
        model_q.delete();
        model_ovr  = 1'b0;
        model_ferr = 1'b0;
    endtask

    // A received frame: good stop bit stores the byte if room, else overrun.
    task automatic model_rx(input logic [7:0] b, input logic good);
        if (!good) begin
            model_ferr = 1'b1;
        end else if (model_q.size() < DEPTH) begin
            model_q.push_back(b);
        end else begin
            model_ovr = 1'b1;
        end
    endtask

    task automatic model_pop();
        if (model_q.size() != 0) begin
            void'(model_q.pop_front());
        end
    endtask

    task automatic compare_state(input string tag);
        logic [7:0] head;
        head = (model_q.size() != 0) ? model_q[0] : 8'h00;
        check({tag, "/valid"}, 32'(sfr_if.rx_valid), 32'(model_q.size() != 0));
        check({tag, "/data"},  32'(sfr_if.rx_data),  32'(head));
        check({tag, "/count"}, 32'(sfr_if.rx_count), 32'(model_q.size()));
        check({tag, "/ovr"},   32'(sfr_if.overrun),  32'(model_ovr));
        check({tag, "/ferr"},  32'(sfr_if.frame_err), 32'(model_ferr));
        check({tag, "/busy"},  32'(sfr_if.busy),     32'(0));
    endtask

    // One 8N1 frame; stop_low > 0 holds the stop bit low for that many bit
    // times. Always finishes with one idle-high bit period.
    task automatic send_frame(input logic [7:0] b, input int stop_low);
        $display("frame %02h stop_low=%0d", b, stop_low);
        uart_rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            cycles(CPB);
        end
        if (stop_low > 0) begin
            uart_rx = 1'b0;
            cycles(stop_low * CPB);
        end
        uart_rx = 1'b1;
        cycles(CPB);
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] head;
        head = (model_q.size() != 0) ? model_q[0] : 8'h00;
        check({tag, "/head"}, 32'(sfr_if.rx_data), 32'(head));
        sfr_if.rd_en = 1'b1;
        cycles(1);
        sfr_if.rd_en = 1'b0;
        model_pop();
        $display("pop head=%02h count=%0d", head, sfr_if.rx_count);
    endtask

    task automatic pulse_clr();
        sfr_if.clr_err = 1'b1;
        cycles(1);
        sfr_if.clr_err = 1'b0;
        model_ovr  = 1'b0;
        model_ferr = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [7:0] seq4 [4];
        logic [7:0] b;
        logic       bad;
        int         k;
        int         np;

        uart_rx        = 1'b1;
        rst            = 1'b1;
        sfr_if.rd_en   = 1'b0;
        sfr_if.clr_err = 1'b0;
        model_clear();
        cycles(4);
        compare_state("reset");
        rst = 1'b0;
        cycles(4);

        // Single byte, then pop back to empty.
        send_frame(8'hA5, 0);
        model_rx(8'hA5, 1'b1);
        compare_state("single");
        pop_one("single");
        compare_state("single_pop");

        // Four frames with no idle gap.
        seq4[0] = 8'h00; seq4[1] = 8'hFF; seq4[2] = 8'h55; seq4[3] = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            send_frame(seq4[i], 0);
            model_rx(seq4[i], 1'b1);
        end
        compare_state("b2b");
        for (int i = 0; i < 4; i++) pop_one("b2b");
        compare_state("b2b_drained");

        // Overrun: fifth byte dropped.
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            send_frame(b, 0);
            model_rx(b, 1'b1);
        end
        compare_state("ovr");
        for (int i = 0; i < 4; i++) pop_one("ovr");
        pulse_clr();
        compare_state("ovr_clr");

        // Framing error with a 3-bit break; busy holds while the line is low.
        fork
            send_frame(8'h12, 3);
            begin
                cycles(11 * CPB);
                check("break/busy", 32'(sfr_if.busy), 32'(1));
                check("break/count", 32'(sfr_if.rx_count), 32'(0));
            end
        join
        model_rx(8'h12, 1'b0);
        compare_state("ferr");
        send_frame(8'h34, 0);
        model_rx(8'h34, 1'b1);
        compare_state("after_break");
        pop_one("after_break");
        pulse_clr();

        // Short low glitch on an idle line.
        uart_rx = 1'b0;
        cycles(4);
        uart_rx = 1'b1;
        cycles(2 * CPB);
        compare_state("glitch");

        // Full FIFO with a pop in the stop-sample cycle: the byte still fits.
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            send_frame(b, 0);
            model_rx(b, 1'b1);
        end
        compare_state("full");
        fork
            send_frame(8'hC3, 0);
            begin
                cycles(STOP_SAMPLE);
                sfr_if.rd_en = 1'b1;
                cycles(1);
                sfr_if.rd_en = 1'b0;
            end
        join
        model_pop();
        model_rx(8'hC3, 1'b1);
        compare_state("pop_at_stop");

        // Clear in the same cycle as a new framing error: the error wins.
        fork
            send_frame(8'h6B, 3);
            begin
                cycles(STOP_SAMPLE);
                sfr_if.clr_err = 1'b1;
                cycles(1);
                sfr_if.clr_err = 1'b0;
            end
        join
        model_rx(8'h6B, 1'b0);
        compare_state("clr_vs_ferr");
        pulse_clr();

        // Drain, then pop an empty FIFO.
        while (model_q.size() != 0) pop_one("drain");
        pop_one("empty_pop");
        compare_state("empty_pop");

        // Line already low when reset is released is not a start bit.
        uart_rx = 1'b0;
        cycles(CPB);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        model_clear();
        cycles(3 * CPB);
        compare_state("low_at_rst");
        uart_rx = 1'b1;
        cycles(CPB);
        send_frame(8'h5A, 0);
        model_rx(8'h5A, 1'b1);
        compare_state("after_low_rst");

        // Reset during bit 3 of 0x7E with a byte buffered; the far end is
        // reset along with the receiver, so the line then idles high.
        b = 8'h7E;
        $display("frame %02h reset in bit 3", b);
        uart_rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 3; i++) begin
            uart_rx = b[i];
            cycles(CPB);
        end
        uart_rx = b[3];
        cycles(CPB / 2);
        pulse_rst();
        compare_state("midrst");
        uart_rx = 1'b1;
        cycles(10 * CPB);
        compare_state("midrst_quiet");
        send_frame(8'h81, 0);
        model_rx(8'h81, 1'b1);
        compare_state("after_midrst");
        pop_one("after_midrst");

        // Randomised bursts, pops and clears.
        for (int r = 0; r < 20; r++) begin
            k = $urandom_range(1, 6);
            for (int f = 0; f < k; f++) begin
                b   = 8'($urandom);
                bad = ($urandom_range(0, 4) == 0);
                send_frame(b, bad ? 3 : 0);
                model_rx(b, !bad);
            end
            compare_state("rnd_rx");
            np = $urandom_range(0, 5);
            for (int p = 0; p < np; p++) pop_one("rnd_pop");
            compare_state("rnd_pop");
            if ($urandom_range(0, 1) == 1) begin
                pulse_clr();
                compare_state("rnd_clr");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
